// File: rtl/beta_dmem_port_if.sv
// Bundles the Beta core LD/ST signals and the handshaked data-memory bus.
// master = the port block, slave = core + memory side driving it.
`timescale 1ns/1ps
interface beta_dmem_port_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0] Adr;
    logic [DW-1:0] WD;
    logic          MOE;
    logic          MWR;
    logic [DW-1:0] RD;
    logic          STALL;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        input  Adr, WD, MOE, MWR, mem_rdata, mem_ack,
        output RD, STALL, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output Adr, WD, MOE, MWR, mem_rdata, mem_ack,
        input  RD, STALL, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/beta_dmem_port.sv
// Beta data-memory port: store buffer, stalling loads, bus-timeout watchdog.
// Define BETA_DMEM_STORE_FWD_EN to enable store-to-load forwarding from the buffer.
`timescale 1ns/1ps
module beta_dmem_port #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int SB_DEPTH = 4,
    parameter int TIMEOUT  = 255,
    localparam int PW      = $clog2(SB_DEPTH),
    localparam int CW      = PW + 1,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    beta_dmem_port_if.master     bus,
    output logic [CW-1:0]        sb_count,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, SREQ, LREQ, LDONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sb_addr_q [SB_DEPTH];
    logic [DW-1:0] sb_data_q [SB_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          st_done_q, st_done_d;

    logic full, empty, mwr_eff, push, pop, ld_elig, timeout, stall, fwd_hit;

    assign full    = (cnt_q == CW'(SB_DEPTH));
    assign empty   = (cnt_q == '0);
    // A store already taken during a combined LD+ST must not be enqueued again
    // while the core keeps MWR held for the load half.
    assign mwr_eff = bus.MWR && !st_done_q;
    assign push    = mwr_eff && !full;
    assign timeout = (tmo_q == TW'(TIMEOUT - 1));

`ifdef BETA_DMEM_STORE_FWD_EN
    logic          match_any;
    logic [DW-1:0] fwd_data;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        match_any = 1'b0;
        fwd_data  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CW'(i) < cnt_q && sb_addr_q[rd_ptr_q + PW'(i)] == bus.Adr) begin
                match_any = 1'b1;
                fwd_data  = sb_data_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    assign fwd_hit = match_any && bus.MOE && !mwr_eff;
    assign ld_elig = bus.MOE && !mwr_eff && !fwd_hit && (state_q == IDLE);
    assign bus.RD  = fwd_hit ? fwd_data : rd_q;
`else
    assign fwd_hit = 1'b0;
    assign ld_elig = bus.MOE && !mwr_eff && empty && (state_q == IDLE);
    assign bus.RD  = rd_q;
`endif

    always_comb begin
        stall = 1'b0;
        if (mwr_eff)
            stall = full || bus.MOE;
        else if (bus.MOE)
            stall = !((state_q == LDONE) || fwd_hit);
    end

    always_comb begin
        st_done_d = st_done_q;
        if (push && bus.MOE)
            st_done_d = 1'b1;
        else if (!stall)
            st_done_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_elig) begin
                    state_d = LREQ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = bus.Adr;
                    tmo_d   = '0;
                end else if (!empty) begin
                    state_d = SREQ;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = sb_addr_q[rd_ptr_q];
                    wdata_d = sb_data_q[rd_ptr_q];
                    tmo_d   = '0;
                end
            end
            SREQ: begin
                if (bus.mem_ack || timeout) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!bus.mem_ack)
                        err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            LREQ: begin
                if (bus.mem_ack) begin
                    rd_d    = bus.mem_rdata;
                    state_d = LDONE;
                    req_d   = 1'b0;
                end else if (timeout) begin
                    rd_d    = '0;
                    err_d   = 1'b1;
                    state_d = LDONE;
                    req_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            LDONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            st_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            st_done_q <= st_done_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_q[wr_ptr_q] <= bus.Adr;
            sb_data_q[wr_ptr_q] <= bus.WD;
        end
    end

    assign bus.STALL     = stall;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign sb_count      = cnt_q;
    assign err           = err_q;
endmodule

// File: tb/tb_beta_dmem_port.sv
// Scoreboard bench for beta_dmem_port: stimulus queues expected memory
// transactions and load data; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_beta_dmem_port;
    logic       clk;
    logic       RESET_N;
    logic [2:0] sb_count;
    logic       err;

    beta_dmem_port_if #(.DW(32), .AW(32)) bus();

    beta_dmem_port #(.DW(32), .AW(32), .SB_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .RESET_N(RESET_N), .bus(bus), .sb_count(sb_count), .err(err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    mem_t        exp_mem[$];
    logic [31:0] exp_rd[$];
    int          total = 0;
    int          bad   = 0;
    int          ack_dly = 0;
    bit          ack_never = 0;
    logic [31:0] rdata_val = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    // Memory responder: acks ack_dly cycles after mem_req is seen.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!RESET_N) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else if (bus.mem_req && !bus.mem_ack && !ack_never) begin
                if (wcnt >= ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata_val;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        mem_t m;
        logic [31:0] r;
        if (RESET_N) begin
            if (bus.mem_req && bus.mem_ack) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected_addr", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                    chk("mem_addr", bus.mem_addr, m.addr);
                    if (m.we)
                        chk("mem_wdata", bus.mem_wdata, m.data);
                end
            end
            if (bus.MOE && !bus.STALL) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", bus.RD, 32'hFFFF_FFFF);
                end else begin
                    r = exp_rd.pop_front();
                    chk("ld_rd", bus.RD, r);
                end
            end
        end
    end

    task automatic do_st(input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output int cnt_go);
        mem_t m;
        m.we = 1'b1; m.addr = a; m.data = d;
        exp_mem.push_back(m);
        bus.Adr = a; bus.WD = d; bus.MWR = 1'b1; bus.MOE = 1'b0;
        stalls = 0;
        @(negedge clk);
        while (bus.STALL && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) chk("st_wait", 32'(bus.STALL), 32'h0);
        cnt_go = int'(sb_count);
        @(posedge clk); #1;
        bus.MWR = 1'b0;
    endtask

    task automatic do_ld(input logic [31:0] a, input logic [31:0] exp,
                         input logic [31:0] rdat, input bit mem_read,
                         output int stalls);
        mem_t m;
        rdata_val = rdat;
        exp_rd.push_back(exp);
        if (mem_read) begin
            m.we = 1'b0; m.addr = a; m.data = 32'h0;
            exp_mem.push_back(m);
        end
        bus.Adr = a; bus.MOE = 1'b1; bus.MWR = 1'b0;
        stalls = 0;
        @(negedge clk);
        while (bus.STALL && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) chk("ld_wait", 32'(bus.STALL), 32'h0);
        @(posedge clk); #1;
        bus.MOE = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb_count != 3'd0 || bus.mem_req) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("drain_sb_count", 32'(sb_count), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int s, c, n;
        int st_stall[5];
        int st_cnt[5];
        mem_t m;

        RESET_N = 1'b0;
        bus.Adr = '0; bus.WD = '0; bus.MOE = 1'b0; bus.MWR = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_RD", bus.RD, 32'h0);
        chk("rst_STALL", 32'(bus.STALL), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_sb_count", 32'(sb_count), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        RESET_N = 1'b1;
        @(posedge clk); #1;

        // Load from empty buffer, immediate ack: exactly two stall cycles.
        ack_dly = 0;
        do_ld(32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, s);
        chk("ld_min_stalls", 32'(s), 32'd2);

        // Store then load to the same address.
        do_st(32'h52, 32'hA8400800, s, c);
        chk("st52_stalls", 32'(s), 32'd0);
`ifdef BETA_DMEM_STORE_FWD_EN
        do_ld(32'h52, 32'hA8400800, 32'h12345678, 1'b0, s);
        chk("fwd_ld_stalls", 32'(s), 32'd0);
`else
        do_ld(32'h52, 32'h12345678, 32'h12345678, 1'b1, s);
        chk("nofwd_ld_stalls", 32'(s), 32'd4);
`endif
        wait_idle();

        // Five back-to-back stores, memory acks three cycles late.
        ack_dly = 3;
        for (int i = 0; i < 5; i++)
            do_st(32'h10 * (i + 1), 32'hA000_0000 + 32'(i), st_stall[i], st_cnt[i]);
        for (int i = 0; i < 4; i++)
            chk("st_burst_no_stall", 32'(st_stall[i]), 32'd0);
        chk("st5_stalled", 32'(st_stall[4] > 0), 32'd1);
        chk("st5_cnt_after_pop", 32'(st_cnt[4]), 32'd3);
        wait_idle();

        // Combined LD+ST with an empty buffer.
        ack_dly = 0;
        rdata_val = 32'hCAFEF00D;
        m.we = 1'b1; m.addr = 32'h200; m.data = 32'h55AA;
        exp_mem.push_back(m);
`ifdef BETA_DMEM_STORE_FWD_EN
        exp_rd.push_back(32'h55AA);
`else
        exp_rd.push_back(32'hCAFEF00D);
        m.we = 1'b0; m.addr = 32'h200; m.data = 32'h0;
        exp_mem.push_back(m);
`endif
        bus.Adr = 32'h200; bus.WD = 32'h55AA; bus.MOE = 1'b1; bus.MWR = 1'b1;
        @(negedge clk);
        chk("mix_stall_first", 32'(bus.STALL), 32'd1);
        chk("mix_cnt_before", 32'(sb_count), 32'd0);
        @(negedge clk);
        chk("mix_cnt_after", 32'(sb_count), 32'd1);
        n = 0;
        while (bus.STALL && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("mix_wait", 32'(bus.STALL), 32'h0);
        @(posedge clk); #1;
        bus.MOE = 1'b0; bus.MWR = 1'b0;
        wait_idle();

        // Load with no ack: abandoned after TIMEOUT cycles, RD=0, err sticky.
        ack_never = 1'b1;
        do_ld(32'h300, 32'h0, 32'h77777777, 1'b0, s);
        chk("tmo_stalls", 32'(s), 32'd9);
        chk("tmo_err", 32'(err), 32'd1);
        ack_never = 1'b0;
        do_st(32'h400, 32'hBEEF0400, s, c);
        chk("post_tmo_st_stalls", 32'(s), 32'd0);
        wait_idle();
        chk("err_sticky", 32'(err), 32'd1);

        // Reset while a load is waiting in LREQ.
        ack_never = 1'b1;
        bus.Adr = 32'h500; bus.MOE = 1'b1;
        repeat (3) @(negedge clk);
        chk("lreq_mem_req", 32'(bus.mem_req), 32'd1);
        chk("lreq_mem_addr", bus.mem_addr, 32'h500);
        #2;
        RESET_N = 1'b0;
        bus.MOE = 1'b0;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        chk("arst_STALL", 32'(bus.STALL), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_sb_count", 32'(sb_count), 32'h0);
        chk("arst_RD", bus.RD, 32'h0);
        @(posedge clk); #1;
        RESET_N = 1'b1;
        ack_never = 1'b0;
        @(negedge clk);
        chk("post_rst_sb_count", 32'(sb_count), 32'h0);
        @(posedge clk); #1;
        do_st(32'h600, 32'h600D0600, s, c);
        chk("post_rst_st_stalls", 32'(s), 32'd0);
        wait_idle();

        chk("exp_mem_left", 32'(exp_mem.size()), 32'd0);
        chk("exp_rd_left", 32'(exp_rd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
